// File: rtl/probe_rx_checker.sv
// probe_rx_checker
//   Receive-side checker for delay-probe frames on a 32-bit big-endian MAC RX
//   Avalon-ST stream. Extracts sequence number and TX timestamp, reports the
//   one-way delay against the shared timestamp counter and keeps saturating
//   statistics counters.
// Ports
//   clk_125m_i, srst_i     : clock, synchronous active-high reset
//   ts_i                   : shared free-running timestamp (ticks)
//   clr_cnt_i              : clear all statistics counters
//   snk_*                  : Avalon-ST sink (data/valid/sop/eop/empty/error/ready)
//   res_valid_o/seq/delay  : one pulse per good probe, seq and delay hold
//   cnt_probe/other/err/gap: good probes, non-probes, bad frames, seq gaps
module probe_rx_checker #(
    parameter logic [15:0] PROBE_ETYPE = 16'h88B5,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_125m_i,
    input  logic             srst_i,
    input  logic [31:0]      ts_i,
    input  logic             clr_cnt_i,
    input  logic [31:0]      snk_data_i,
    input  logic             snk_valid_i,
    input  logic             snk_sop_i,
    input  logic             snk_eop_i,
    input  logic [1:0]       snk_empty_i,
    input  logic [5:0]       snk_error_i,
    output logic             snk_ready_o,
    output logic             res_valid_o,
    output logic [31:0]      res_seq_o,
    output logic [31:0]      res_delay_o,
    output logic [CNT_W-1:0] cnt_probe_o,
    output logic [CNT_W-1:0] cnt_other_o,
    output logic [CNT_W-1:0] cnt_err_o,
    output logic [CNT_W-1:0] cnt_gap_o
);

    typedef enum logic [1:0] {IDLE, PARSE, SKIP, REPORT} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    logic [2:0]  widx;
    logic [31:0] rx_ts, seq, txts, exp_seq;
    logic        non_probe, err_flag, have_prev;

    logic        beat, in_frame, etype_bad, frame_err;
    logic [31:0] txts_fin;
    logic        inc_probe, inc_other, inc_err, inc_gap;

    // The empty field carries no information for this checker.
    logic unused_empty;
    assign unused_empty = ^snk_empty_i;

    always_comb begin
        beat      = snk_valid_i && snk_ready_o;
        in_frame  = (state == PARSE) || (state == SKIP);
        etype_bad = (state == PARSE) && (widx == 3'd3) &&
                    (snk_data_i[31:16] != PROBE_ETYPE);
        // Only meaningful on an EOP beat: EOP before W5 is a runt.
        frame_err = ((state == PARSE) && (widx < 3'd5)) || (|snk_error_i);
        // EOP on W5 reports in the next cycle, so merge the low half in now.
        txts_fin  = ((state == PARSE) && (widx == 3'd5)) ?
                    {txts[31:16], snk_data_i[31:16]} : txts;
        inc_err   = ((state == REPORT) && err_flag) ||
                    (beat && snk_sop_i && in_frame);
        inc_other = (state == REPORT) && !err_flag && non_probe;
        inc_probe = (state == REPORT) && !err_flag && !non_probe;
        inc_gap   = inc_probe && have_prev && (seq != exp_seq);
    end

    always_ff @(posedge clk_125m_i) begin
        if (srst_i) begin
            state       <= IDLE;
            widx        <= 3'd0;
            rx_ts       <= '0;
            seq         <= '0;
            txts        <= '0;
            exp_seq     <= '0;
            non_probe   <= 1'b0;
            err_flag    <= 1'b0;
            have_prev   <= 1'b0;
            snk_ready_o <= 1'b1;
            res_valid_o <= 1'b0;
            res_seq_o   <= '0;
            res_delay_o <= '0;
        end else begin
            res_valid_o <= 1'b0;
            if (state == REPORT) begin
                snk_ready_o <= 1'b1;
                state       <= IDLE;
                if (!err_flag && !non_probe) begin
                    exp_seq   <= seq + 32'd1;
                    have_prev <= 1'b1;
                end
            end else if (beat && snk_sop_i) begin
                // New frame; any frame still open is aborted (counted above).
                rx_ts     <= ts_i;
                widx      <= 3'd1;
                non_probe <= 1'b0;
                if (snk_eop_i) begin
                    err_flag    <= 1'b1;
                    state       <= REPORT;
                    snk_ready_o <= 1'b0;
                end else begin
                    state <= PARSE;
                end
            end else if (beat && in_frame) begin
                if (state == PARSE) begin
                    widx <= widx + 3'd1;
                    case (widx)
                        3'd3: begin
                            seq[31:16] <= snk_data_i[15:0];
                            if (etype_bad) non_probe <= 1'b1;
                        end
                        3'd4: begin
                            seq[15:0]   <= snk_data_i[31:16];
                            txts[31:16] <= snk_data_i[15:0];
                        end
                        3'd5: txts[15:0] <= snk_data_i[31:16];
                        default: ;
                    endcase
                end
                if (snk_eop_i) begin
                    err_flag    <= frame_err;
                    state       <= REPORT;
                    snk_ready_o <= 1'b0;
                    if (!frame_err && !non_probe) begin
                        res_valid_o <= 1'b1;
                        res_seq_o   <= seq;
                        res_delay_o <= rx_ts - txts_fin;
                    end
                end else if ((state == PARSE) && (etype_bad || widx == 3'd5)) begin
                    state <= SKIP;
                end
            end
        end
    end

    // Statistics: clear wins over increments, all counters stick at all-ones.
    always_ff @(posedge clk_125m_i) begin
        if (srst_i || clr_cnt_i) begin
            cnt_probe_o <= '0;
            cnt_other_o <= '0;
            cnt_err_o   <= '0;
            cnt_gap_o   <= '0;
        end else begin
            if (inc_probe && (cnt_probe_o != '1)) cnt_probe_o <= cnt_probe_o + CNT_ONE;
            if (inc_other && (cnt_other_o != '1)) cnt_other_o <= cnt_other_o + CNT_ONE;
            if (inc_err   && (cnt_err_o   != '1)) cnt_err_o   <= cnt_err_o   + CNT_ONE;
            if (inc_gap   && (cnt_gap_o   != '1)) cnt_gap_o   <= cnt_gap_o   + CNT_ONE;
        end
    end

endmodule
